// File: rtl/stack_pkg.sv
// Shared defaults and width helpers for the LIFO stack.
package stack_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;

  // Stack pointer counts 0..DEPTH inclusive, so it needs one bit beyond the index.
  localparam int SP_W_DEF = $clog2(DEPTH_DEF) + 1;

  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Index width into storage; at least one bit so a depth-1 stack still elaborates.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Request decode: encoding matches {pop, push}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/stack_mem.sv
// Word storage for the stack: register array, synchronous write, combinational read.
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AW         = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // Contents are deliberately not reset; an entry is only read after it was pushed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack.sv
// LIFO stack: pointer, sticky error flag and registered pop data around stack_mem.
module stack
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error
);

  localparam int SP_W = sp_width(DEPTH);
  localparam int AW   = addr_width(DEPTH);

  logic [SP_W-1:0]       sp;
  op_e                   op;
  logic                  full, empty;
  logic                  do_push;
  logic [AW-1:0]         wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Decode the request and the occupancy flags; push+pop together decodes to a no-op.
  always_comb begin
    op      = op_e'({pop, push});
    full    = (sp == SP_W'(DEPTH));
    empty   = (sp == '0);
    do_push = (op == OP_PUSH) && !full;
    wr_idx  = AW'(sp);
    rd_idx  = AW'(sp - SP_W'(1));
  end

  stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_idx),
    .wdata (data_in),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  // Pointer, error and pop data; rejected requests only raise error, which stays set
  // until an accepted push or pop clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp       <= '0;
      error    <= 1'b0;
      data_out <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (full) begin
            error <= 1'b1;
          end else begin
            sp    <= sp + SP_W'(1);
            error <= 1'b0;
          end
        end
        OP_POP: begin
          if (empty) begin
            error <= 1'b1;
          end else begin
            sp       <= sp - SP_W'(1);
            data_out <= rd_word;
            error    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack.sv
// Self-checking bench for the stack: directed table, corner sequences, random vs queue model.
module tb_stack;

  logic       clk;
  logic       reset;
  logic       push, pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       error;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain queue with the stack top at the back.
  logic [7:0] mdl_q[$];
  logic [7:0] mdl_dout;
  logic       mdl_err;

  typedef struct {
    logic       p;
    logic       q;
    logic [7:0] d;
    logic [7:0] dout;
    logic       err;
  } vec_t;

  vec_t tbl[12];

  stack dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given request, then sample 1 time unit after the edge.
  task automatic step(input logic p, input logic q, input logic [7:0] d);
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_dout", data_out, 0);
    chk("reset_err",  error,    0);
    chk("reset_sp",   dut.sp,   0);
    @(negedge clk);
    reset = 1'b1;
    mdl_q.delete();
    mdl_dout = 8'h00;
    mdl_err  = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic q, input logic [7:0] d);
    if (p && !q) begin
      if (mdl_q.size() < 16) begin
        mdl_q.push_back(d);
        mdl_err = 1'b0;
      end else begin
        mdl_err = 1'b1;
      end
    end else if (q && !p) begin
      if (mdl_q.size() > 0) begin
        mdl_dout = mdl_q.pop_back();
        mdl_err  = 1'b0;
      end else begin
        mdl_err = 1'b1;
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = 8'h00;

    // Directed table applied from a fresh reset.
    tbl[0]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1};  // underflow
    tbl[1]  = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h3C, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h77, 8'h00, 1'b0};  // push+pop no-op
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 8'h3C, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 8'hA5, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 8'hA5, 1'b1};  // underflow, dout held
    tbl[8]  = '{1'b1, 1'b1, 8'h99, 8'hA5, 1'b1};  // no-op keeps sticky error
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 8'hA5, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'h11, 8'hA5, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].p, tbl[i].q, tbl[i].d);
      chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].dout);
      chk($sformatf("tbl%0d_err", i),  error,    tbl[i].err);
    end

    // Fill with 0x00..0x0F on separated cycles.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk($sformatf("fill%0d_err", i), error, 0);
      step(1'b0, 1'b0, 8'h00);
    end
    chk("fill_sp", dut.sp, 16);

    // Overflow leaves contents intact.
    step(1'b1, 1'b0, 8'h00);
    chk("ovf_err",  error,    1);
    chk("ovf_sp",   dut.sp,   16);
    chk("ovf_dout", data_out, 0);

    // Drain: reverse order, error clears on first pop.
    for (int i = 15; i >= 0; i--) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain%0d_dout", i), data_out, i);
      chk($sformatf("drain%0d_err", i),  error,    0);
    end

    step(1'b0, 1'b1, 8'h00);
    chk("unf_err",  error,    1);
    chk("unf_dout", data_out, 8'h00);
    chk("unf_sp",   dut.sp,   0);

    // Single push/pop of 0xFF.
    do_reset();
    step(1'b1, 1'b0, 8'hFF);
    step(1'b0, 1'b1, 8'h00);
    chk("ff_dout", data_out, 8'hFF);
    chk("ff_err",  error,    0);

    // Simultaneous push+pop, then reset asynchronously mid-sequence.
    do_reset();
    step(1'b1, 1'b0, 8'h21);
    step(1'b1, 1'b0, 8'h42);
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h63);
    chk("both_dout", data_out, 8'h42);
    chk("both_err",  error,    0);
    chk("both_sp",   dut.sp,   1);
    push    = 1'b1;
    data_in = 8'h84;
    #2;
    reset = 1'b0;
    #1;
    chk("async_dout", data_out, 0);
    chk("async_err",  error,    0);
    chk("async_sp",   dut.sp,   0);
    @(posedge clk);
    #1;
    chk("rsthold_sp", dut.sp, 0);
    push = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 8'h5A);
    chk("post_rst_sp", dut.sp, 1);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_dout", data_out, 8'h5A);
    chk("post_rst_err",  error,    0);

    // Randomized run against the queue model, phases biased to hit full and empty.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int ph, pth, qth;
      logic p, q;
      logic [7:0] d;
      ph  = (i / 100) % 3;
      pth = (ph == 0) ? 75 : (ph == 1) ? 20 : 45;
      qth = (ph == 0) ? 20 : (ph == 1) ? 75 : 45;
      p   = ($urandom_range(0, 99) < pth);
      q   = ($urandom_range(0, 99) < qth);
      d   = 8'($urandom);
      step(p, q, d);
      model_step(p, q, d);
      chk($sformatf("rnd%0d_dout", i), data_out, mdl_dout);
      chk($sformatf("rnd%0d_err", i),  error,    mdl_err);
      chk($sformatf("rnd%0d_sp", i),   dut.sp,   mdl_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stack.md
STACK -- requirements
Module: stack

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 8, as the width of each stored word.
REQ-002 The block SHALL provide parameter DEPTH, default 16, as the maximum number of stored words.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port push, input, 1 bit: push request, sampled at the clk rising edge.
REQ-007 Port pop, input, 1 bit: pop request, sampled at the clk rising edge.
REQ-008 Port data_in, input, DATA_WIDTH bits: word written on an accepted push.
REQ-009 Port data_out, output, DATA_WIDTH bits: registered word returned by the last accepted pop.
REQ-010 Port error, output, 1 bit: registered overflow/underflow flag.

Function
REQ-011 The block SHALL be a LIFO with internal count sp, ranging 0..DEPTH; width is clog2(DEPTH)+1.
- empty means sp==0.
- full means sp==DEPTH.
REQ-012 On an edge with push=1, pop=0 and not full:
- mem[sp] <= data_in.
- sp <= sp+1.
- error <= 0.
REQ-013 On an edge with pop=1, push=0 and not empty:
- data_out <= mem[sp-1].
- sp <= sp-1.
- error <= 0.
REQ-014 Pop latency SHALL be one cycle: data_out is valid after the edge that accepts the pop.
REQ-015 Push while full (overflow) SHALL set error <= 1 and leave sp, the memory and data_out unchanged.
REQ-016 Pop while empty (underflow) SHALL set error <= 1 and leave sp, the memory and data_out unchanged.
REQ-017 error SHALL be sticky: it holds until the next accepted push or pop, or until reset.
REQ-018 An edge with push=1 and pop=1 together SHALL be a no-op: sp, memory, data_out and error all unchanged.
REQ-019 An edge with push=0 and pop=0 SHALL hold all state.
REQ-020 data_out SHALL hold its value between pops; pushes never modify it.
REQ-021 The block SHALL never wrap sp past DEPTH or below 0, and SHALL never overwrite memory when full.

Reset
REQ-022 While reset==0, the block SHALL force sp=0, data_out=0 and error=0 immediately, independent of clk.
REQ-023 Memory contents need not be reset; they SHALL be unobservable until pushed.
REQ-024 Reset asserted mid-operation SHALL abort any in-flight request; the stack is empty after release.
REQ-025 The first edge after reset deassertion SHALL process push/pop normally.

Structure
REQ-026 A shared package stack_pkg SHALL hold:
- the DATA_WIDTH and DEPTH defaults;
- the derived pointer width constant.
REQ-027 Storage SHALL be a sub-module stack_mem: a DEPTH x DATA_WIDTH register array with synchronous write and combinational read by index.
REQ-028 Control (sp, error, data_out) SHALL reside in stack.

Verification
REQ-029 Reset, then push 0x00..0x0F on 16 separated cycles -> error=0 throughout; the stack is full.
REQ-030 Full stack, then push 0x00 -> error=1 one cycle later; the contents are unchanged.
REQ-031 From the REQ-030 state, 16 pops -> data_out = 0x0F, 0x0E, ... 0x00 in order; error clears on the first pop.
REQ-032 Empty stack, then pop -> error=1; data_out stays 0x00.
REQ-033 Reset, push 0xFF, then pop -> data_out=0xFF after the pop edge; error=0.
REQ-034 Push and pop asserted together, and reset asserted mid-sequence:
- simultaneous push+pop -> no state change;
- reset -> data_out=0, error=0 and the stack empty, immediately.
